// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
//   CLA_GRP_W     - width of one lookahead group (fixed 4-bit groups)
//   cla_grp_pg    - reduces per-bit propagate/generate of a group to group P/G
//   cla_stg_ctl_t - per-stage control record (valid + slice carry-out). The
//                   width-dependent parts of a stage record (sum so far and the
//                   not-yet-consumed operand bits) change size from stage to
//                   stage, so they are declared inside each stage's scope.
package cla_pkg;

   localparam int CLA_GRP_W = 4;

   typedef struct packed {
      logic valid;
      logic carry;
   } cla_stg_ctl_t;

   // Returns {P, G} for one 4-bit group.
   function automatic logic [1:0] cla_grp_pg(input logic [3:0] p, input logic [3:0] g);
      logic gp, gg;
      gp = &p;
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return {gp, gg};
   endfunction

endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group.
//   a_i, b_i : group operand bits
//   c_i      : carry into the group
//   s_o      : group sum bits
//   p_o, g_o : group propagate / generate for the slice-level lookahead
module cla_group4
   import cla_pkg::*;
(
   input  logic [CLA_GRP_W-1:0] a_i,
   input  logic [CLA_GRP_W-1:0] b_i,
   input  logic                 c_i,
   output logic [CLA_GRP_W-1:0] s_o,
   output logic                 p_o,
   output logic                 g_o
);

   logic [CLA_GRP_W-1:0] p, g, cy;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   // Internal carries fully expanded so no bit waits on its neighbour.
   assign cy[0] = c_i;
   assign cy[1] = g[0] | (p[0] & c_i);
   assign cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
   assign cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);

   assign s_o        = p ^ cy;
   assign {p_o, g_o} = cla_grp_pg(p, g);

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder, one result per cycle.
//   Stage k adds operand slice k (WIDTH/STAGES bits) using the carry registered
//   by stage k-1. Operand bits not yet consumed ride along in skew registers;
//   completed sum bits ride along to the output so S is coherent.
// Parameters: WIDTH (multiple of 4*STAGES), STAGES (>=1)
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready, a,b,c  input handshake, operands, carry-in
//   out_valid/out_ready, S,C  output handshake, sum mod 2^WIDTH, carry-out
//   sub, ovf                  subtract select / signed overflow (CLA_SUB_EN only)
// Build option: define CLA_SUB_EN to add the subtract/overflow feature.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
`ifdef CLA_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             C
);

   localparam int SW = WIDTH / STAGES;   // bits per slice
   localparam int NG = SW / CLA_GRP_W;   // groups per slice

   // Subtraction is folded in at the input, so the inverted B and forced
   // carry-in travel with the transaction instead of a separate sub bit.
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
`ifdef CLA_SUB_EN
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub | c;
`else
   assign b_eff = b;
   assign c_eff = c;
`endif

   // Stage k may load when empty or when the stage after it moves on.
   logic [STAGES:0]   en;
   logic [STAGES-1:0] vld;

   always_comb begin
      en         = '0;
      en[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) en[k] = !vld[k] || en[k+1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int HI = (k + 1) * SW;   // sum bits complete after this stage

      logic [SW-1:0] sa, sb, ssum;
      logic [NG-1:0] gp, gg;
      logic [NG:0]   gc;                  // gc[NG] is the slice carry-out
      logic          ci, vin;
      logic [HI-1:0] sum_d, sum_q;
      cla_stg_ctl_t  ctl_q;

      if (k == 0) begin : g_src
         assign sa    = a[SW-1:0];
         assign sb    = b_eff[SW-1:0];
         assign ci    = c_eff;
         assign vin   = in_valid;
         assign sum_d = ssum;
      end else begin : g_src
         assign sa    = g_stg[k-1].g_skew.a_q[SW-1:0];
         assign sb    = g_stg[k-1].g_skew.b_q[SW-1:0];
         assign ci    = g_stg[k-1].ctl_q.carry;
         assign vin   = g_stg[k-1].ctl_q.valid;
         assign sum_d = {ssum, g_stg[k-1].sum_q};
      end

      for (genvar j = 0; j < NG; j++) begin : g_grp
         cla_group4 u_grp (
            .a_i (sa[j*CLA_GRP_W +: CLA_GRP_W]),
            .b_i (sb[j*CLA_GRP_W +: CLA_GRP_W]),
            .c_i (gc[j]),
            .s_o (ssum[j*CLA_GRP_W +: CLA_GRP_W]),
            .p_o (gp[j]),
            .g_o (gg[j])
         );
      end

      // Group carries as flat sum-of-products over group P/G:
      // gc[j] = OR_i (gg[i] & gp[i+1..j-1]) | (gp[0..j-1] & ci)
      always_comb begin
         logic acc, prod;
         gc    = '0;
         gc[0] = ci;
         for (int j = 1; j <= NG; j++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
               acc  = acc | (gg[i] & prod);
               prod = prod & gp[i];
            end
            gc[j] = acc | (prod & ci);
         end
      end

      // Data only moves with a real transaction; bubbles leave it untouched,
      // which keeps S/C steady between results.
      always_ff @(posedge clk) begin
         if (rst) begin
            ctl_q <= '0;
            sum_q <= '0;
         end else if (en[k]) begin
            ctl_q.valid <= vin;
            if (vin) begin
               ctl_q.carry <= gc[NG];
               sum_q       <= sum_d;
            end
         end
      end

      assign vld[k] = ctl_q.valid;

      // Operand bits still to be added by later stages.
      if (k < STAGES - 1) begin : g_skew
         logic [WIDTH-HI-1:0] a_d, b_d, a_q, b_q;
         if (k == 0) begin : g_in
            assign a_d = a[WIDTH-1:HI];
            assign b_d = b_eff[WIDTH-1:HI];
         end else begin : g_in
            assign a_d = g_stg[k-1].g_skew.a_q[WIDTH-k*SW-1:SW];
            assign b_d = g_stg[k-1].g_skew.b_q[WIDTH-k*SW-1:SW];
         end
         always_ff @(posedge clk) begin
            if (en[k] && vin) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end
   end

`ifdef CLA_SUB_EN
   // Signed overflow from the top slice's operand and sum sign bits.
   logic ovf_d, ovf_q;
   assign ovf_d = (g_stg[STAGES-1].sa[SW-1] == g_stg[STAGES-1].sb[SW-1]) &&
                  (g_stg[STAGES-1].ssum[SW-1] != g_stg[STAGES-1].sa[SW-1]);
   always_ff @(posedge clk) begin
      if (rst)                                      ovf_q <= 1'b0;
      else if (en[STAGES-1] && g_stg[STAGES-1].vin) ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`endif

   assign in_ready  = en[0];
   assign out_valid = vld[STAGES-1];
   assign S         = g_stg[STAGES-1].sum_q;
   assign C         = g_stg[STAGES-1].ctl_q.carry;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench: a 16-bit/2-stage adder for directed cases and a
// 32-bit/4-stage adder for a random stream with random backpressure.
module tb_cla_pipe_adder;
   localparam int W = 16, ST = 2, XW = 32, XST = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0, out_ready = 1'b1, c = 1'b0, sub = 1'b0;
   logic          in_ready, out_valid, C;
   logic [W-1:0]  a = '0, b = '0, S;
   logic          x_in_valid = 1'b0, x_out_ready = 1'b1, x_c = 1'b0;
   logic          x_in_ready, x_out_valid, x_C;
   logic [XW-1:0] x_a = '0, x_b = '0, x_S;
`ifdef CLA_SUB_EN
   logic          ovf, x_ovf;
`endif

   cla_pipe_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c(c),
`ifdef CLA_SUB_EN
      .sub(sub), .ovf(ovf),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .S(S), .C(C)
   );

   cla_pipe_adder #(.WIDTH(XW), .STAGES(XST)) u_dut_x (
      .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
      .a(x_a), .b(x_b), .c(x_c),
`ifdef CLA_SUB_EN
      .sub(1'b0), .ovf(x_ovf),
`endif
      .out_valid(x_out_valid), .out_ready(x_out_ready), .S(x_S), .C(x_C)
   );

   typedef struct {
      logic [XW:0] sum;
      logic        ovf;
      int          t;
   } exp_t;

   exp_t q[$];
   exp_t xq[$];
   int   n_cmp = 0, n_err = 0, cyc_n = 0, x_got = 0;
   bit   lat_chk = 1'b0, acc = 1'b0, xacc = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   function automatic exp_t model16(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                    input logic cc, input logic ss);
      exp_t         e;
      logic [W-1:0] be;
      logic         cin;
      logic [W:0]   r;
      be    = ss ? ~bb : bb;
      cin   = ss ? 1'b1 : cc;
      r     = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, cin};
      e.sum = '0;
      e.sum[W:0] = r;
      e.ovf = (aa[W-1] == be[W-1]) && (r[W-1] != aa[W-1]);
      e.t   = cyc_n;
      return e;
   endfunction

   function automatic exp_t model32(input logic [XW-1:0] aa, input logic [XW-1:0] bb, input logic cc);
      exp_t e;
      e.sum = {1'b0, aa} + {1'b0, bb} + {{XW{1'b0}}, cc};
      e.ovf = 1'b0;
      e.t   = cyc_n;
      return e;
   endfunction

   // Called just after a negedge with inputs set; records transfers that the
   // coming posedge will make, then advances to the next negedge.
   task automatic step();
      exp_t e;
      #1;
      acc  = 1'b0;
      xacc = 1'b0;
      if (!rst) begin
         if (in_valid && in_ready) begin
            q.push_back(model16(a, b, c, sub));
            acc = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
               e = q.pop_front();
               chk("S", S, e.sum[W-1:0]);
               chk("C", C, e.sum[W]);
`ifdef CLA_SUB_EN
               chk("ovf", ovf, e.ovf);
`endif
               if (lat_chk) chk("latency", cyc_n - e.t, ST);
            end
         end
         if (x_in_valid && x_in_ready) begin
            xq.push_back(model32(x_a, x_b, x_c));
            xacc = 1'b1;
         end
         if (x_out_valid && x_out_ready) begin
            if (xq.size() == 0) chk("x_spurious_out", x_out_valid, 0);
            else begin
               e = xq.pop_front();
               chk("xS", x_S, e.sum[XW-1:0]);
               chk("xC", x_C, e.sum[XW]);
               x_got++;
            end
         end
      end
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic xfer(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc, input logic ss);
      a = aa; b = bb; c = cc; sub = ss;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (acc) break;
      end
      if (!acc) chk("xfer_timeout", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q.size() > 0 || xq.size() > 0); i++) step();
      chk("drain_empty", q.size() + xq.size(), 0);
   endtask

   initial begin
      @(negedge clk);
      step();
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_S", S, 0);
      chk("rst_C", C, 0);
      chk("rst_x_out_valid", x_out_valid, 0);
      rst = 1'b0;
      chk("rdy_after_rst", in_ready, 1);

      // all-ones + carry-in ripples through both stages
      lat_chk = 1'b1;
      xfer(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      step();
      chk("wrap_valid", out_valid, 1);
      chk("wrap_S", S, 16'h0000);
      chk("wrap_C", C, 1);
      drain();

      // back-to-back stream
      xfer(16'd8, 16'd7, 1'b0, 1'b0);
      xfer(16'd2, 16'd3, 1'b1, 1'b0);
      xfer(16'd1, 16'd7, 1'b0, 1'b0);
      drain();
      lat_chk = 1'b0;

      // backpressure: pipe fills, in_ready drops, output holds
      out_ready = 1'b0;
      xfer(16'd10, 16'd20, 1'b0, 1'b0);
      xfer(16'd30, 16'd40, 1'b1, 1'b0);
      a = 16'd50; b = 16'd60; c = 1'b0; in_valid = 1'b1;
      repeat (3) begin
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_S", S, 16'd30);
         chk("stall_C", C, 0);
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (acc) break;
      end
      chk("stall_accept", acc, 1);
      in_valid = 1'b0;
      drain();

      // reset with two in flight
      xfer(16'd100, 16'd200, 1'b0, 1'b0);
      xfer(16'd300, 16'd400, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_S", S, 0);
      chk("mid_rst_C", C, 0);
      q.delete();
      xq.delete();
      rst = 1'b0;
      repeat (4) begin
         chk("no_stale", out_valid, 0);
         step();
      end

`ifdef CLA_SUB_EN
      xfer(16'd5, 16'd7, 1'b0, 1'b1);
      xfer(16'h8000, 16'd1, 1'b0, 1'b1);
      xfer(16'h1234, 16'h0234, 1'b1, 1'b1);
      sub = 1'b0;
      drain();
`endif

      // random stream with random backpressure on the wide instance
      x_got = 0;
      for (int i = 0; i < 40000 && x_got < 10000; i++) begin
         if (!x_in_valid || xacc) begin
            x_in_valid = ($urandom_range(0, 4) != 0);
            x_a = $urandom;
            x_b = $urandom;
            x_c = 1'($urandom_range(0, 1));
            if (i % 97 == 0) begin
               x_a = '1;
               x_b = '0;
               x_c = 1'b1;
            end
         end
         x_out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      chk("rand_count", x_got, 10000);
      x_in_valid  = 1'b0;
      x_out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
